chunked_negate: RTL

Multi-cycle, parametrised two's-complement unit that negates, takes the absolute value of, or passes an N-bit operand. It processes the operand C bits per cycle, LSB chunk first. A one-bit "seen a one" flag carries across chunks, and each chunk reuses the prefix-OR negation network. It sits on valid/ready streams between arithmetic stages where a full-width single-cycle negator would miss timing.

---
 rtl/chunked_negate_pkg.sv | 20 ++
 rtl/prefix_or.sv | 23 ++
 rtl/chunked_negate.sv | 123 ++++++++++++
 3 files changed

// File: rtl/chunked_negate_pkg.sv
// chunked_negate_pkg
// Shared types for the chunked two's-complement negate/abs unit.
//   mode_e  : operation select carried on in_mode
//   state_e : control states of the chunk sequencer
package chunked_negate_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_NEG  = 2'd1,
        MODE_ABS  = 2'd2,
        MODE_RSVD = 2'd3   // treated as pass-through
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/prefix_or.sv
// prefix_or
// Inclusive prefix-OR network: p[i] = |a[i:0].
//   a : input vector, W bits
//   p : prefix-OR result, W bits
module prefix_or #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] p
);

    logic acc;

    always_comb begin
        p   = '0;
        acc = 1'b0;
        for (int i = 0; i < W; i++) begin
            acc  = acc | a[i];
            p[i] = acc;
        end
    end

endmodule

// File: rtl/chunked_negate.sv
// chunked_negate
// Multi-cycle negate / absolute-value / pass unit. The operand is processed
// C bits per cycle, LSB chunk first, with a "seen a one" flag carried between
// chunks so each chunk only needs a C-wide prefix-OR.
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : operand handshake (accepted only from idle)
//   in_data, in_mode     : operand and operation (PASS/NEG/ABS/reserved=PASS)
//   out_valid/out_ready  : result handshake
//   out_data, out_ovf    : result, and flag for negating the most negative value
module chunked_negate
    import chunked_negate_pkg::*;
#(
    parameter int N = 32,
    parameter int C = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf
);

    localparam int K  = N / C;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    if (N < 2 || C < 1 || C > N || (N % C) != 0) begin : g_bad_params
        $error("chunked_negate: need N >= 2 and N a multiple of C");
    end

    state_e        state;
    logic [N-1:0]  opnd;
    logic          neg;
    logic          seen;
    logic [KW-1:0] k;

    logic [C-1:0]  chunk;
    logic [C-1:0]  pfx;
    logic [C-1:0]  res;
    logic          acc;
    logic          last;
    logic          neg_in;
    mode_e         mode;

    assign mode   = mode_e'(in_mode);
    // ABS only negates when the operand is negative.
    assign neg_in = (mode == MODE_NEG) || ((mode == MODE_ABS) && in_data[N-1]);

    // in_ready is decoded from state; gated by rst so it reads 0 during reset.
    assign in_ready = (state == S_IDLE) && !rst;

    assign chunk = opnd[int'(k)*C +: C];
    assign last  = (k == KW'(K-1));

    prefix_or #(.W(C)) u_pfx (
        .a (chunk),
        .p (pfx)
    );

    // Two's-complement negate: bits up to and including the first one are
    // kept, every bit above it is inverted. acc is "a one exists below bit i",
    // combining the carried flag with the in-chunk prefix.
    always_comb begin
        res = '0;
        acc = seen;
        for (int i = 0; i < C; i++) begin
            res[i] = chunk[i] ^ (neg & acc);
            acc    = seen | pfx[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            opnd      <= '0;
            neg       <= 1'b0;
            seen      <= 1'b0;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        opnd    <= in_data;
                        neg     <= neg_in;
                        // Only -MOST_NEG overflows; the bitwise network then
                        // naturally returns the operand unchanged.
                        out_ovf <= neg_in && (in_data == MOST_NEG);
                        seen    <= 1'b0;
                        k       <= '0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    out_data[int'(k)*C +: C] <= res;
                    if (neg)
                        seen <= seen | pfx[C-1];
                    if (last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
